lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 The module SHALL have parameter MEM_BYTES, default 1024, giving the data memory size in bytes; addresses at or above it are out of range.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  CPU-side access request.
REQ-005 req_ready  output  1  request accepted when req_valid and req_ready are both high at posedge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
REQ-009 req_addr  input  32 (addr_t)  byte address.
REQ-010 req_wdata  input  32 (word_t)  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 resp_err  output  1  misaligned, illegal size or out-of-range; valid with resp_valid.
REQ-014 mem_addr  output  32  word-aligned memory address, bits [1:0] always 00.
REQ-015 mem_wdata  output  32  memory write data.
REQ-016 mem_we  output  1  memory write enable; memory writes at posedge when high.
REQ-017 mem_rdata  input  32  combinational memory read data for mem_addr.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 On acceptance in IDLE, the FSM SHALL latch addr, size, we, unsigned and wdata, and set mem_addr = {req_addr[31:2], 2'b00}.
REQ-020 Error check at acceptance: size 11; half with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_BYTES. On error the FSM SHALL go IDLE->RESP, with no mem_we cycle.
REQ-021 A legal request SHALL go IDLE->ACCESS.
REQ-022 ACCESS, load: capture mem_rdata; extract the lane at byte offset addr[1:0] (little-endian, byte i = bits [8i+7:8i]); extend per req_unsigned; go RESP.
REQ-023 ACCESS, word store: mem_we=1, mem_wdata=latched wdata; go RESP.
REQ-024 ACCESS, byte/half store: mem_we=0; merge latched wdata into the selected lane(s) of mem_rdata; register the merged word; go WRITE.
REQ-025 WRITE: mem_we=1, mem_wdata=merged word; go RESP.
REQ-026 RESP: resp_valid=1 for exactly one cycle; go IDLE.
REQ-027 mem_we SHALL be decoded from the state only, and is high for at most one cycle per store.
REQ-028 Latency from acceptance edge to resp_valid: error 1 cycle, load and word store 2 cycles, sub-word store 3 cycles.
REQ-029 resp_rdata and resp_err SHALL hold their values until the next response.
REQ-030 A request presented outside IDLE SHALL be ignored; the requester holds it until req_ready is high.

Reset
REQ-031 While rst is high, the FSM SHALL be IDLE, req_ready=1, and resp_valid, resp_err, mem_we, mem_addr, mem_wdata and resp_rdata SHALL all be 0.
REQ-032 Reset asserted mid-operation SHALL drop mem_we immediately, abandon the access, and produce no response.

Verification
REQ-033 mem[0x10]=0x8899AABB; lb 0x11 -> resp_rdata 0xFFFFFFAA, resp_err 0, resp_valid 2 cycles after acceptance; lbu 0x11 -> 0x000000AA.
REQ-034 Same word; lh 0x12 -> 0xFFFF8899; lhu 0x12 -> 0x00008899; lw 0x10 -> 0x8899AABB.
REQ-035 sb 0x12 wdata 0x12345655 -> exactly one mem_we cycle with mem_addr 0x10, mem_wdata 0x8855AABB; resp_valid 3 cycles after acceptance; readback lw 0x10 = 0x8855AABB.
REQ-036 lw 0x13, sh 0x11, size 11, and lw 0x400 (MEM_BYTES=1024) -> resp_err 1, resp_rdata 0, no mem_we, resp_valid 1 cycle after acceptance.
REQ-037 sh 0x10 with rst pulsed during WRITE -> mem_we falls with rst, no resp_valid, req_ready 1, mem[0x10] unchanged.
REQ-038 Back-to-back requests with req_valid held high -> each accepted only in IDLE, responses in order, one resp_valid per request.

Source files
------------

// File: rtl/lsu_if.sv
// Shared types and the CPU/memory bus bundle of the load/store unit.
// The LSU takes the slave modport; the requester and memory together drive the master side.
package lsu_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_ILL = 2'b11} size_t;
endpackage

interface lsu_if;
    import lsu_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    addr_t       req_addr;
    word_t       req_wdata;
    logic        resp_valid;
    word_t       resp_rdata;
    logic        resp_err;
    addr_t       mem_addr;
    word_t       mem_wdata;
    logic        mem_we;
    word_t       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one outstanding access to a word-wide memory with a combinational read port.
// Sub-word stores are read-modify-write: read in ACCESS, write the merged word in WRITE.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t     state_q, state_d;
    size_t      size_q;
    logic [1:0] off_q;
    logic       we_q;
    logic       uns_q;
    word_t      wdata_q;
    word_t      merged_q;
    addr_t      mem_addr_q;
    word_t      rdata_q;
    logic       err_q;

    logic       req_err;
    logic       word_store;
    logic [4:0] shamt;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;
    word_t      load_data;
    word_t      lane_mask;
    word_t      merge_data;

    assign req_err = (bus.req_size == SZ_ILL)
                  || (bus.req_size == SZ_HALF && bus.req_addr[0])
                  || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
                  || (bus.req_addr >= MEM_BYTES);

    assign word_store = we_q && (size_q == SZ_WORD);

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = req_err ? RESP : ACCESS;
            ACCESS:  state_d = (we_q && !word_store) ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction and merge, little-endian: byte i lives in bits [8i+7:8i].
    always_comb begin
        shamt    = {off_q, 3'b000};
        byte_sel = bus.mem_rdata[shamt +: 8];
        half_sel = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
        unique case (size_q)
            SZ_BYTE: load_data = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = bus.mem_rdata;
        endcase
        lane_mask  = (size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
        merge_data = (bus.mem_rdata & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            size_q     <= SZ_BYTE;
            off_q      <= 2'b00;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            merged_q   <= '0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: if (bus.req_valid) begin
                    size_q     <= size_t'(bus.req_size);
                    off_q      <= bus.req_addr[1:0];
                    we_q       <= bus.req_we;
                    uns_q      <= bus.req_unsigned;
                    wdata_q    <= bus.req_wdata;
                    mem_addr_q <= {bus.req_addr[31:2], 2'b00};
                    if (req_err) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_data;
                        err_q   <= 1'b0;
                    end else if (word_store) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end else begin
                        merged_q <= merge_data;
                    end
                end
                WRITE: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // mem_we comes straight from registered state, so reset removes it without waiting for a clock.
    assign bus.mem_we     = (state_q == WRITE) || (state_q == ACCESS && word_store);
    assign bus.mem_wdata  = (state_q == WRITE)                  ? merged_q :
                            (state_q == ACCESS && word_store)   ? wdata_q  : '0;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: byte-array reference model, directed vectors, random and back-to-back traffic.
module tb_lsu;
    localparam int MEM_BYTES = 1024;
    localparam int WORDS     = MEM_BYTES / 4;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   errors = 0;
    int   checks = 0;

    lsu_if bus ();
    lsu #(.MEM_BYTES(MEM_BYTES)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Memory seen by the DUT, and the bench's own byte-level model of what it should hold.
    logic [31:0] mem     [WORDS];
    logic [7:0]  ref_mem [MEM_BYTES];
    int          we_cnt  = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_data = '0;

    assign bus.mem_rdata = (bus.mem_addr[31:2] < 30'(WORDS)) ? mem[bus.mem_addr[9:2]] : 32'h0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < WORDS; i++)
                mem[i] <= {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]};
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            we_cnt  <= we_cnt + 1;
            we_addr <= bus.mem_addr;
            we_data <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one request; commits store effects to ref_mem.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd,
                                  output int lat, output logic [31:0] wword);
        int nb;
        logic [31:0] v;
        logic [31:0] aw;
        nb    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err   = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= MEM_BYTES);
        rd    = 32'h0;
        wword = 32'h0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            v = 32'h0;
            for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[a + k]) << (8 * k));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            rd  = v;
            lat = 2;
        end else begin
            for (int k = 0; k < nb; k++) ref_mem[a + k] = wd[8*k +: 8];
            aw    = a & ~32'h3;
            wword = {ref_mem[aw+3], ref_mem[aw+2], ref_mem[aw+1], ref_mem[aw]};
            lat   = (nb == 4) ? 2 : 3;
        end
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic        e_err;
        logic [31:0] e_rd, e_word;
        int          e_lat, lat, start_we;
        model(we, sz, uns, a, wd, e_err, e_rd, e_lat, e_word);
        @(negedge clk);
        for (int i = 0; i < 10 && !bus.req_ready; i++) @(negedge clk);
        check("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
        bus.req_unsigned = uns; bus.req_addr = a; bus.req_wdata = wd;
        start_we = we_cnt;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.resp_valid && lat < 8);
        check("latency", 32'(lat), 32'(e_lat));
        check("resp_rdata", bus.resp_rdata, e_rd);
        check("resp_err", 32'(bus.resp_err), 32'(e_err));
        check("mem_we_cycles", 32'(we_cnt - start_we), (we && !e_err) ? 32'd1 : 32'd0);
        if (we && !e_err) begin
            check("write_addr", we_addr, a & ~32'h3);
            check("write_data", we_data, e_word);
        end
        rd = bus.resp_rdata;
        @(negedge clk);
        check("resp_single_pulse", 32'(bus.resp_valid), 32'd0);
        check("resp_rdata_hold", bus.resp_rdata, e_rd);
    endtask

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic [31:0] rd;
    exp_t        q[$];
    exp_t        e;

    initial begin
        logic        r_we, r_uns, m_err;
        logic [1:0]  r_sz;
        logic [31:0] r_a, r_wd, m_rd, m_word;
        int          m_lat, sent, got, seen_resp;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom);
        {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]} = 32'h8899_AABB;
        rst = 1'b1; preload = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        rst = 1'b0;

        // Directed loads, sub-word store and error cases.
        do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd);  check("lb_0x11", rd, 32'hFFFF_FFAA);
        do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, rd);  check("lbu_0x11", rd, 32'h0000_00AA);
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd);  check("lh_0x12", rd, 32'hFFFF_8899);
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd);  check("lhu_0x12", rd, 32'h0000_8899);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);  check("lw_0x10", rd, 32'h8899_AABB);
        do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h1234_5655, rd);
        check("sb_write_data", we_data, 32'h8855_AABB);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);  check("lw_after_sb", rd, 32'h8855_AABB);
        do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, rd);
        do_req(1'b1, 2'd1, 1'b0, 32'h11, 32'hBEEF, rd);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, rd);
        do_req(1'b0, 2'd1, 1'b1, 32'h3FE, 32'h0, rd);

        // Reset during the WRITE cycle of a sub-word store.
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd1;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0000_7777;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("write_cycle_we", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_drops_we", 32'(bus.mem_we), 32'd0);
        check("rst_mid_ready", 32'(bus.req_ready), 32'd1);
        check("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_resp = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen_resp++;
        end
        check("rst_no_response", 32'(seen_resp), 32'd0);
        check("rst_mem_unchanged", mem[4], 32'h8855_AABB);
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);  check("lw_after_rst", rd, 32'h8855_AABB);

        // Random single requests against the model.
        for (int n = 0; n < 40; n++) begin
            r_we = 1'($urandom);
            r_sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_a  = ($urandom_range(0, 7) == 0) ? 32'(MEM_BYTES - 4 + $urandom_range(0, 7)) : 32'($urandom_range(0, 63));
            do_req(r_we, r_sz, 1'($urandom), r_a, $urandom, rd);
        end

        // Back-to-back: req_valid held high, next request presented only once req_ready returns.
        sent = 0; got = 0; seen_resp = 0;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                if (q.size() == 0) begin
                    seen_resp++;
                end else begin
                    e = q.pop_front();
                    check("b2b_rdata", bus.resp_rdata, e.rd);
                    check("b2b_err", 32'(bus.resp_err), 32'(e.err));
                    got++;
                end
            end
            if (bus.req_ready) begin
                if (sent < 16) begin
                    r_we = 1'($urandom);
                    r_sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                    r_a  = 32'($urandom_range(0, 31));
                    r_wd = $urandom;
                    bus.req_valid = 1'b1; bus.req_we = r_we; bus.req_size = r_sz;
                    bus.req_unsigned = 1'($urandom); bus.req_addr = r_a; bus.req_wdata = r_wd;
                    model(r_we, r_sz, bus.req_unsigned, r_a, r_wd, m_err, m_rd, m_lat, m_word);
                    q.push_back('{rd: m_rd, err: m_err});
                    sent++;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen_resp++;
        end
        check("b2b_responses", 32'(got), 32'd16);
        check("b2b_extra_responses", 32'(seen_resp), 32'd0);
        for (int i = 0; i < WORDS; i++)
            check("final_mem", mem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
